coin_acceptor: RTL and testbench



---
 rtl/coin_pkg.sv | 22 ++
 rtl/coin_acceptor_if.sv | 36 +++
 rtl/coin_debounce.sv | 57 +++++
 rtl/coin_acceptor.sv | 168 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared types and default constants for the coin acceptor front-end.
// Optional per-coin pulse counters are enabled with the COIN_COUNT_EN macro.
package coin_pkg;

  typedef enum logic {
    COIN_QUARTER = 1'b0,
    COIN_DOLLAR  = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int GAP_CYCLES_DEF = 3;
  localparam int JAM_CYCLES_DEF = 1024;
  localparam int COUNT_W        = 16;

endpackage

// File: rtl/coin_acceptor_if.sv
// Controller-facing signal bundle of the coin acceptor.
// COIN_COUNT_EN adds the dollar_count / quarter_count outputs.
interface coin_acceptor_if;
  import coin_pkg::*;

  // vm_busy acts as an inverted ready: a queued coin is popped only in a cycle
  // where vm_busy is low; D_in / Q_in are single-cycle valid pulses with no
  // back-pressure once issued.
  logic vm_busy;
  logic D_in;
  logic Q_in;
  logic fifo_full;
  logic coin_reject;
  logic jam_err;
`ifdef COIN_COUNT_EN
  logic [COUNT_W-1:0] dollar_count;
  logic [COUNT_W-1:0] quarter_count;
`endif

  modport master (
    input  vm_busy,
    output D_in, Q_in, fifo_full, coin_reject, jam_err
`ifdef COIN_COUNT_EN
    , output dollar_count, quarter_count
`endif
  );

  modport slave (
    output vm_busy,
    input  D_in, Q_in, fifo_full, coin_reject, jam_err
`ifdef COIN_COUNT_EN
    , input dollar_count, quarter_count
`endif
  );

endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce filter, registered
// rising-edge event and jam timer on the filtered level.
module coin_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise,
  output logic jam_hit
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int JW = $clog2(JAM_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] deb_cnt;
  logic [JW-1:0] jam_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      deb_cnt <= '0;
      jam_cnt <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      // Level flips only after DEB_CYCLES consecutive disagreeing samples.
      if (sync2 == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        level   <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (!level) begin
        jam_cnt <= '0;
      end else if (jam_cnt != JW'(JAM_CYCLES)) begin
        jam_cnt <= jam_cnt + JW'(1);
      end
    end
  end

  assign jam_hit = (jam_cnt == JW'(JAM_CYCLES));

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced sensor channels feeding a coin queue that is
// drained by a pulse sequencer (IDLE/PULSE/GAP). COIN_COUNT_EN adds counters.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int JAM_CYCLES = JAM_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            coin_dollar_raw,
  input  logic            coin_quarter_raw,
  coin_acceptor_if.master bus,
  output seq_state_t      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  logic          rise_d, rise_q, jam_d, jam_q;
  logic          ev_d, ev_q;
  logic          push, pop, wr_ok, full_now, reject_n;
  coin_t         push_coin, head;
  logic          skid_valid, skid_valid_n;
  coin_t         skid_coin, skid_coin_n;
  coin_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          full_q, reject_q, jam_err_q;
  seq_state_t    state;
  logic [GW-1:0] gap_cnt;
  logic          d_q, q_q;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_dollar (
    .clk(clk), .rst_n(rst_n), .raw(coin_dollar_raw), .rise(rise_d), .jam_hit(jam_d)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_quarter (
    .clk(clk), .rst_n(rst_n), .raw(coin_quarter_raw), .rise(rise_q), .jam_hit(jam_q)
  );

  assign ev_d = rise_d & ~jam_err_q;
  assign ev_q = rise_q & ~jam_err_q;

  // Push arbitration: a held skid coin goes first, then dollar, then quarter.
  // A channel cannot re-rise on the cycle after its own rise, so the skid is
  // never asked to hold two coins at once.
  always_comb begin
    push         = 1'b0;
    push_coin    = COIN_DOLLAR;
    skid_valid_n = 1'b0;
    skid_coin_n  = skid_coin;
    if (skid_valid) begin
      push      = 1'b1;
      push_coin = skid_coin;
      if (ev_d) begin
        skid_valid_n = 1'b1;
        skid_coin_n  = COIN_DOLLAR;
      end else if (ev_q) begin
        skid_valid_n = 1'b1;
        skid_coin_n  = COIN_QUARTER;
      end
    end else if (ev_d) begin
      push      = 1'b1;
      push_coin = COIN_DOLLAR;
      if (ev_q) begin
        skid_valid_n = 1'b1;
        skid_coin_n  = COIN_QUARTER;
      end
    end else if (ev_q) begin
      push      = 1'b1;
      push_coin = COIN_QUARTER;
    end
  end

  assign head       = mem[rd_ptr];
  assign full_now   = (count == CW'(FIFO_DEPTH));
  assign pop        = (state == IDLE) && (count != '0) && !bus.vm_busy;
  assign wr_ok      = push && (!full_now || pop);
  assign reject_n   = push && full_now && !pop;
  assign count_next = count + CW'(wr_ok) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= COIN_QUARTER;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      reject_q   <= 1'b0;
      skid_valid <= 1'b0;
      skid_coin  <= COIN_QUARTER;
      jam_err_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= push_coin;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      full_q     <= (count_next == CW'(FIFO_DEPTH));
      reject_q   <= reject_n;
      skid_valid <= skid_valid_n;
      skid_coin  <= skid_coin_n;
      jam_err_q  <= jam_err_q | jam_d | jam_q;
    end
  end

  // GAP lasts GAP_CYCLES-1 cycles; the IDLE decision cycle supplies the last
  // quiet cycle, so back-to-back pulses are exactly 1+GAP_CYCLES apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      d_q     <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      d_q <= 1'b0;
      q_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= PULSE;
            d_q   <= (head == COIN_DOLLAR);
            q_q   <= (head == COIN_QUARTER);
          end
        end
        PULSE: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 2)) state <= IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_COUNT_EN
  logic [COUNT_W-1:0] dollar_cnt, quarter_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dollar_cnt  <= '0;
      quarter_cnt <= '0;
    end else begin
      if (d_q && (dollar_cnt != '1)) dollar_cnt <= dollar_cnt + COUNT_W'(1);
      if (q_q && (quarter_cnt != '1)) quarter_cnt <= quarter_cnt + COUNT_W'(1);
    end
  end

  assign bus.dollar_count  = dollar_cnt;
  assign bus.quarter_count = quarter_cnt;
`endif

  assign bus.D_in        = d_q;
  assign bus.Q_in        = q_q;
  assign bus.fifo_full   = full_q;
  assign bus.coin_reject = reject_q;
  assign bus.jam_err     = jam_err_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters
// (DEB_CYCLES=4, FIFO_DEPTH=4, GAP_CYCLES=3, JAM_CYCLES=1024).
module tb_coin_acceptor;
  import coin_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_dollar_raw = 1'b0;
  logic       coin_quarter_raw = 1'b0;
  seq_state_t dbg_state;
  int         checks = 0;
  int         failures = 0;

  coin_acceptor_if bus ();

  coin_acceptor dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin_dollar_raw(coin_dollar_raw),
    .coin_quarter_raw(coin_quarter_raw),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Raw line high 8 cycles then low 10; counts rejects and output pulses seen.
  task automatic drive_coin(input bit dollar, inout int rej, inout int pulses);
    if (dollar) coin_dollar_raw = 1'b1;
    else coin_quarter_raw = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 8) begin
        coin_dollar_raw  = 1'b0;
        coin_quarter_raw = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.coin_reject) rej++;
      if (bus.D_in || bus.Q_in) pulses++;
    end
  endtask

  task automatic test_reset;
    bus.vm_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.D_in !== 1'b0) begin failures++; $display("FAIL reset_d_in: got %b want 0", bus.D_in); end
    checks++;
    if (bus.Q_in !== 1'b0) begin failures++; $display("FAIL reset_q_in: got %b want 0", bus.Q_in); end
    checks++;
    if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL reset_fifo_full: got %b want 0", bus.fifo_full); end
    checks++;
    if (bus.coin_reject !== 1'b0) begin failures++; $display("FAIL reset_reject: got %b want 0", bus.coin_reject); end
    checks++;
    if (bus.jam_err !== 1'b0) begin failures++; $display("FAIL reset_jam: got %b want 0", bus.jam_err); end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_dollar;
    int first_d = -1;
    int nd = 0;
    int nq = 0;
    coin_dollar_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) coin_dollar_raw = 1'b0;
      @(posedge clk); #1;
      if (bus.D_in) begin
        if (first_d < 0) first_d = k;
        nd++;
      end
      if (bus.Q_in) nq++;
    end
    checks++;
    if (first_d !== 8) begin failures++; $display("FAIL single_latency: got %0d want 8", first_d); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL single_d_count: got %0d want 1", nd); end
    checks++;
    if (nq !== 0) begin failures++; $display("FAIL single_q_count: got %0d want 0", nq); end
  endtask

  task automatic test_bounce;
    int first_q = -1;
    int nd = 0;
    int nq = 0;
    for (int k = 0; k < 50; k++) begin
      if (k < 12) coin_quarter_raw = ((k % 4) < 2);
      else coin_quarter_raw = (k < 32);
      @(posedge clk); #1;
      if (bus.Q_in) begin
        if (first_q < 0) first_q = k;
        nq++;
      end
      if (bus.D_in) nd++;
    end
    checks++;
    if (nq !== 1) begin failures++; $display("FAIL bounce_q_count: got %0d want 1", nq); end
    checks++;
    if (first_q !== 20) begin failures++; $display("FAIL bounce_latency: got %0d want 20", first_q); end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL bounce_d_count: got %0d want 0", nd); end
  endtask

  task automatic test_simultaneous;
    int first_d = -1;
    int first_q = -1;
    int nd = 0;
    int nq = 0;
    int both = 0;
    coin_dollar_raw  = 1'b1;
    coin_quarter_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) begin
        coin_dollar_raw  = 1'b0;
        coin_quarter_raw = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.D_in && bus.Q_in) both++;
      if (bus.D_in) begin
        if (first_d < 0) first_d = k;
        nd++;
      end
      if (bus.Q_in) begin
        if (first_q < 0) first_q = k;
        nq++;
      end
    end
    checks++;
    if (first_d !== 8) begin failures++; $display("FAIL simul_d_time: got %0d want 8", first_d); end
    checks++;
    if (first_q !== 12) begin failures++; $display("FAIL simul_q_time: got %0d want 12", first_q); end
    checks++;
    if (nd !== 1 || nq !== 1) begin failures++; $display("FAIL simul_counts: got d=%0d q=%0d want d=1 q=1", nd, nq); end
    checks++;
    if (both !== 0) begin failures++; $display("FAIL simul_overlap: got %0d want 0", both); end
`ifdef COIN_COUNT_EN
    checks++;
    if (bus.dollar_count !== 16'd2 || bus.quarter_count !== 16'd2) begin
      failures++;
      $display("FAIL pulse_counters: got d=%0d q=%0d want d=2 q=2", bus.dollar_count, bus.quarter_count);
    end
`endif
  endtask

  task automatic test_fifo_full_reject;
    int rej = 0;
    int pulses = 0;
    int n = 0;
    int both = 0;
    int st [4];
    logic [3:0] types;
    types = 4'b0000;
    for (int i = 0; i < 4; i++) st[i] = -1;
    bus.vm_busy = 1'b1;
    drive_coin(1'b1, rej, pulses);
    drive_coin(1'b0, rej, pulses);
    drive_coin(1'b1, rej, pulses);
    drive_coin(1'b0, rej, pulses);
    drive_coin(1'b1, rej, pulses);
    checks++;
    if (rej !== 1) begin failures++; $display("FAIL full_reject_count: got %0d want 1", rej); end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL busy_pulses: got %0d want 0", pulses); end
    checks++;
    if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL fifo_full_set: got %b want 1", bus.fifo_full); end
    bus.vm_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.D_in && bus.Q_in) both++;
      if (bus.D_in || bus.Q_in) begin
        if (n < 4) begin
          types[n] = bus.D_in;
          st[n] = k;
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL drain_count: got %0d want 4", n); end
    checks++;
    if (types !== 4'b0101) begin failures++; $display("FAIL drain_order: got %b want 0101", types); end
    checks++;
    if (st[0] !== 0 || st[1] !== 4 || st[2] !== 8 || st[3] !== 12) begin
      failures++;
      $display("FAIL drain_spacing: got %0d %0d %0d %0d want 0 4 8 12", st[0], st[1], st[2], st[3]);
    end
    checks++;
    if (both !== 0) begin failures++; $display("FAIL drain_overlap: got %0d want 0", both); end
    checks++;
    if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL fifo_full_clear: got %b want 0", bus.fifo_full); end
  endtask

  task automatic test_jam;
    int nd = 0;
    int nq = 0;
    coin_dollar_raw = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk); #1;
      if (bus.D_in) nd++;
      if (k == 1000) begin
        checks++;
        if (bus.jam_err !== 1'b0) begin failures++; $display("FAIL jam_early: got %b want 0", bus.jam_err); end
      end
    end
    checks++;
    if (bus.jam_err !== 1'b1) begin failures++; $display("FAIL jam_set: got %b want 1", bus.jam_err); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL jam_dollar_pulses: got %0d want 1", nd); end
    coin_dollar_raw = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    coin_quarter_raw = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 20) coin_quarter_raw = 1'b0;
      @(posedge clk); #1;
      if (bus.Q_in) nq++;
    end
    checks++;
    if (nq !== 0) begin failures++; $display("FAIL jam_blocks_quarter: got %0d want 0", nq); end
    checks++;
    if (bus.jam_err !== 1'b1) begin failures++; $display("FAIL jam_sticky: got %b want 1", bus.jam_err); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.jam_err !== 1'b0) begin failures++; $display("FAIL jam_reset_clear: got %b want 0", bus.jam_err); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int rej = 0;
    int pulses = 0;
    bit found = 1'b0;
    bus.vm_busy = 1'b1;
    drive_coin(1'b1, rej, pulses);
    drive_coin(1'b0, rej, pulses);
    drive_coin(1'b1, rej, pulses);
    bus.vm_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!found) begin
        @(posedge clk); #1;
        if (bus.D_in || bus.Q_in) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_first_pulse: got none want one within 20 cycles"); end
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== GAP) begin failures++; $display("FAIL midreset_in_gap: got %0d want %0d", dbg_state, GAP); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.D_in, bus.Q_in, bus.fifo_full, bus.coin_reject, bus.jam_err} !== 5'b00000) begin
      failures++;
      $display("FAIL midreset_outputs: got %b want 00000", {bus.D_in, bus.Q_in, bus.fifo_full, bus.coin_reject, bus.jam_err});
    end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL midreset_state: got %0d want %0d", dbg_state, IDLE); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.D_in || bus.Q_in) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midreset_no_pulses: got %0d want 0", pulses); end
  endtask

  initial begin
    bus.vm_busy = 1'b0;
    test_reset();
    test_single_dollar();
    test_bounce();
    test_simultaneous();
    test_fifo_full_reject();
    test_jam();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
